prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, meaning the data and address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the queue entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port RST_VEC, input, SIZE bits: the address of the reset-vector word (0xFFFE in system use).
REQ-006 The block SHALL have port fetch_req, output, 1 bit: read request to the memory space.
REQ-007 The block SHALL have port fetch_addr, output, SIZE bits: the word address presented with fetch_req.
REQ-008 The block SHALL have port fetch_ack, input, 1 bit: mem_rdata is valid for fetch_addr in this cycle.
REQ-009 The block SHALL have port mem_rdata, input, SIZE bits: the read data from memory.
REQ-010 The block SHALL have port instr_word, output, SIZE bits: the head-entry instruction or extension word.
REQ-011 The block SHALL have port instr_pc, output, SIZE bits: the address the head entry was fetched from.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: the head entry is valid.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: the decoder consumes the head entry.
REQ-014 The block SHALL have port redirect, input, 1 bit: a PC change (jump, call, ret, reti, PC write).
REQ-015 The block SHALL have port redirect_addr, input, SIZE bits: the new fetch address.
REQ-016 The block SHALL have port count, output, clog2(DEPTH+1) bits: the occupied entries.

Function
REQ-017 The block SHALL implement a two-state FSM, BOOT then RUN; RUN SHALL persist until rst.
REQ-018 In BOOT the block SHALL drive fetch_req=1 and fetch_addr=RST_VEC; on fetch_ack it SHALL load fetch_addr with mem_rdata & ~1, enter RUN, and push nothing.
REQ-019 In RUN, fetch_req SHALL equal (count < DEPTH) and SHALL be a function of registered state only, with no combinational path from instr_ready, redirect or fetch_ack.
REQ-020 A push SHALL occur when fetch_req && fetch_ack && !redirect in RUN: {mem_rdata, fetch_addr} SHALL be written at the tail, and fetch_addr SHALL advance by 2, wrapping modulo 2^SIZE.
REQ-021 A pop SHALL occur when instr_valid && instr_ready && !redirect, and the head SHALL advance.
REQ-022 On a simultaneous push and pop, count SHALL be unchanged, and a push into an empty queue SHALL become visible the next cycle, with no bypass.
REQ-023 instr_valid SHALL equal (count != 0); instr_word and instr_pc SHALL be the head entry and are don't-care when invalid.
REQ-024 With redirect=1 in RUN, the next cycle SHALL have count=0 and head=tail, and fetch_addr SHALL equal redirect_addr & ~1; any push or pop in that cycle SHALL be discarded.
REQ-025 redirect SHALL be ignored in BOOT.
REQ-026 The head and tail pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be: state=BOOT, count=0, head=tail=0, fetch_addr=RST_VEC.
REQ-028 The outputs after reset SHALL be: fetch_req=1, instr_valid=0, count=0.
REQ-029 rst SHALL take priority over redirect, push and pop.
REQ-030 A reset mid-operation SHALL discard all entries and restart BOOT.
REQ-031 The storage array SHALL need no reset.

Structure
REQ-032 The shared package/include msp430_defs SHALL hold the state encoding (BOOT, RUN) and PC_STEP=2.
REQ-033 The storage SHALL be one sub-module, pq_storage: a DEPTH x 2*SIZE register array with one write port and one asynchronous read port.
REQ-034 The pointers, count and FSM SHALL reside in prefetch_queue.

Verification
REQ-035 Boot: rst pulse, then memory[0xFFFE]=0xC001 with fetch_ack=1 -> fetch_addr=0xC000 in RUN, and the first pushed instr_pc=0xC000.
REQ-036 Fill: instr_ready=0 and fetch_ack=1 -> four pushes at 0xC000, 0xC002, 0xC004, 0xC006; count=4; fetch_req=0; fetch_addr=0xC008.
REQ-037 Full plus pop: from full, instr_ready=1 for one cycle -> count=3; fetch_req=1 the next cycle; then a push of 0xC008.
REQ-038 Redirect: count=3 and redirect=1 with redirect_addr=0xC101, with instr_ready=1 and fetch_ack=1 in the same cycle -> next cycle count=0, instr_valid=0, fetch_addr=0xC100.
REQ-039 Wrap: redirect to 0xFFFC -> pushes with instr_pc 0xFFFC, 0xFFFE, 0x0000.
REQ-040 Reset mid-stream: count=2 and rst=1 -> next cycle state=BOOT, count=0, fetch_addr=RST_VEC, and redirect in BOOT has no effect.

Source files
------------

// File: rtl/msp430_defs.sv
// Shared definitions for the instruction prefetch path: fetch FSM encoding
// and the byte distance between consecutive instruction words.
package msp430_defs;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } pq_state_t;

   localparam int PC_STEP = 2;

endpackage

// File: rtl/pq_storage.sv
// Prefetch queue entry store: one synchronous write port, one asynchronous
// read port. Contents are not reset; occupancy is tracked by the owner.
module pq_storage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches the reset vector, then streams
// sequential instruction words into a small FIFO until redirected.
module prefetch_queue
   import msp430_defs::*;
#(
   parameter int SIZE  = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SIZE-1:0]            RST_VEC,
   output logic                       fetch_req,
   output logic [SIZE-1:0]            fetch_addr,
   input  logic                       fetch_ack,
   input  logic [SIZE-1:0]            mem_rdata,
   output logic [SIZE-1:0]            instr_word,
   output logic [SIZE-1:0]            instr_pc,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   input  logic                       redirect,
   input  logic [SIZE-1:0]            redirect_addr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output pq_state_t                  fsm_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [SIZE-1:0] ALIGN_MASK = ~SIZE'(1);

   pq_state_t         state_q, state_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SIZE-1:0]   addr_q, addr_d;
   logic              push, pop;
   logic [2*SIZE-1:0] head_entry;

   // Handshakes: a memory word transfers when fetch_req && fetch_ack; the head
   // transfers when instr_valid && instr_ready. A redirect in RUN cancels both.
   assign fetch_req   = (state_q == BOOT) || (cnt_q < CW'(DEPTH));
   assign fetch_addr  = (state_q == BOOT) ? RST_VEC : addr_q;
   assign instr_valid = (cnt_q != '0);
   assign count       = cnt_q;
   assign fsm_state   = state_q;

   assign push = (state_q == RUN) && fetch_req && fetch_ack && !redirect;
   assign pop  = instr_valid && instr_ready && !redirect;

   pq_storage #(
      .WIDTH (2*SIZE),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (tail_q),
      .wdata ({mem_rdata, addr_q}),
      .raddr (head_q),
      .rdata (head_entry)
   );

   assign instr_word = head_entry[2*SIZE-1:SIZE];
   assign instr_pc   = head_entry[SIZE-1:0];

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      case (state_q)
         BOOT: begin
            // The reset-vector word is a pointer, not an instruction: nothing is queued.
            if (fetch_ack) begin
               addr_d  = mem_rdata & ALIGN_MASK;
               state_d = RUN;
            end
         end
         RUN: begin
            if (redirect) begin
               cnt_d  = '0;
               head_d = tail_q;
               addr_d = redirect_addr & ALIGN_MASK;
            end else begin
               if (push) begin
                  tail_d = tail_q + PW'(1);
                  addr_d = addr_q + SIZE'(PC_STEP);
               end
               if (pop) begin
                  head_d = head_q + PW'(1);
               end
               case ({push, pop})
                  2'b10:   cnt_d = cnt_q + CW'(1);
                  2'b01:   cnt_d = cnt_q - CW'(1);
                  default: cnt_d = cnt_q;
               endcase
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= RST_VEC;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed vector table for boot/fill/redirect/wrap/reset,
// then randomized traffic against a reference model with an entry scoreboard.
module tb_prefetch_queue;
   import msp430_defs::*;

   localparam int SIZE  = 16;
   localparam int DEPTH = 4;

   logic              clk;
   logic              rst;
   logic [SIZE-1:0]   rst_vec;
   logic              fetch_req;
   logic [SIZE-1:0]   fetch_addr;
   logic              fetch_ack;
   logic [SIZE-1:0]   mem_rdata;
   logic [SIZE-1:0]   instr_word;
   logic [SIZE-1:0]   instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [SIZE-1:0]   redirect_addr;
   logic [2:0]        count;
   pq_state_t         fsm_state;

   prefetch_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .RST_VEC       (rst_vec),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_ack     (fetch_ack),
      .mem_rdata     (mem_rdata),
      .instr_word    (instr_word),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .count         (count),
      .fsm_state     (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: reset vector holds 0xC001, every other word is a pattern of its address
   function automatic logic [SIZE-1:0] mem_model(input logic [SIZE-1:0] a);
      if (a == 16'hFFFE) return 16'hC001;
      return a ^ 16'hA5A5;
   endfunction

   assign mem_rdata = mem_model(fetch_addr);

   int checks   = 0;
   int failures = 0;

   logic [2*SIZE-1:0] exp_q[$];

   // reference model state
   pq_state_t       m_state;
   int              m_cnt;
   logic [SIZE-1:0] m_addr;

   typedef struct {
      logic            rst;
      logic            ack;
      logic            rdy;
      logic            rdr;
      logic [SIZE-1:0] raddr;
      pq_state_t       st;
      logic [2:0]      cnt;
      logic            req;
      logic            vld;
      logic [SIZE-1:0] addr;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // model step, evaluated on pre-edge values; pops are compared against the scoreboard
   task automatic model_step(input logic r, input logic a, input logic rd, input logic rdr,
                             input logic [SIZE-1:0] ra);
      logic [2*SIZE-1:0] e;
      logic do_push, do_pop;
      if (r) begin
         m_state = BOOT;
         m_cnt   = 0;
         m_addr  = rst_vec;
         exp_q.delete();
      end else if (m_state == BOOT) begin
         if (a) begin
            m_addr  = mem_model(rst_vec) & 16'hFFFE;
            m_state = RUN;
         end
      end else if (rdr) begin
         m_cnt  = 0;
         m_addr = ra & 16'hFFFE;
         exp_q.delete();
      end else begin
         do_pop  = (m_cnt != 0) && rd;
         do_push = (m_cnt < DEPTH) && a;
         if (do_pop) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_valid", {31'd0, instr_valid}, 32'd1);
               chk("sb_word", {16'd0, instr_word}, {16'd0, e[2*SIZE-1:SIZE]});
               chk("sb_pc", {16'd0, instr_pc}, {16'd0, e[SIZE-1:0]});
            end
         end
         if (do_push) begin
            exp_q.push_back({mem_model(m_addr), m_addr});
            m_addr = m_addr + 16'd2;
         end
         m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      end
   endtask

   // driver: apply one cycle of inputs, return #1 after the active edge
   task automatic step(input logic r, input logic a, input logic rd, input logic rdr,
                       input logic [SIZE-1:0] ra);
      @(negedge clk);
      rst           = r;
      fetch_ack     = a;
      instr_ready   = rd;
      redirect      = rdr;
      redirect_addr = ra;
      #1;
      model_step(r, a, rd, rdr, ra);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_vec       = 16'hFFFE;
      rst           = 1'b1;
      fetch_ack     = 1'b0;
      instr_ready   = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      m_state       = BOOT;
      m_cnt         = 0;
      m_addr        = 16'hFFFE;

      //            rst   ack   rdy   rdr   raddr     st    cnt  req   vld   addr
      vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, BOOT, 3'd0, 1'b1, 1'b0, 16'hFFFE});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, BOOT, 3'd0, 1'b1, 1'b0, 16'hFFFE});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, RUN,  3'd0, 1'b1, 1'b0, 16'hC000});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd1, 1'b1, 1'b1, 16'hC002});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd2, 1'b1, 1'b1, 16'hC004});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd3, 1'b1, 1'b1, 16'hC006});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd4, 1'b0, 1'b1, 16'hC008});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd4, 1'b0, 1'b1, 16'hC008});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, RUN,  3'd3, 1'b1, 1'b1, 16'hC008});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd4, 1'b0, 1'b1, 16'hC00A});
      vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, RUN,  3'd3, 1'b1, 1'b1, 16'hC00A});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'hC101, RUN,  3'd0, 1'b1, 1'b0, 16'hC100});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd1, 1'b1, 1'b1, 16'hC102});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, RUN,  3'd1, 1'b1, 1'b1, 16'hC104});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC, RUN,  3'd0, 1'b1, 1'b0, 16'hFFFC});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd1, 1'b1, 1'b1, 16'hFFFE});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd2, 1'b1, 1'b1, 16'h0000});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd3, 1'b1, 1'b1, 16'h0002});
      vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, RUN,  3'd2, 1'b1, 1'b1, 16'h0002});
      vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, RUN,  3'd2, 1'b1, 1'b1, 16'h0004});
      vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, BOOT, 3'd0, 1'b1, 1'b0, 16'hFFFE});
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h4444, BOOT, 3'd0, 1'b1, 1'b0, 16'hFFFE});
      vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, RUN,  3'd0, 1'b1, 1'b0, 16'hC000});

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].ack, vq[i].rdy, vq[i].rdr, vq[i].raddr);
         chk($sformatf("row%0d state", i), {31'd0, fsm_state}, {31'd0, vq[i].st});
         chk($sformatf("row%0d count", i), {29'd0, count}, {29'd0, vq[i].cnt});
         chk($sformatf("row%0d fetch_req", i), {31'd0, fetch_req}, {31'd0, vq[i].req});
         chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vq[i].vld});
         chk($sformatf("row%0d fetch_addr", i), {16'd0, fetch_addr}, {16'd0, vq[i].addr});
      end

      // randomized traffic with occasional redirects and resets
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
              SIZE'($urandom_range(0, 65535)));
         chk("rnd state", {31'd0, fsm_state}, {31'd0, m_state});
         chk("rnd count", {29'd0, count}, 32'(m_cnt));
         chk("rnd fetch_req", {31'd0, fetch_req}, {31'd0, (m_state == BOOT) || (m_cnt < DEPTH)});
         chk("rnd instr_valid", {31'd0, instr_valid}, {31'd0, m_cnt != 0});
         chk("rnd fetch_addr", {16'd0, fetch_addr}, {16'd0, (m_state == BOOT) ? rst_vec : m_addr});
      end

      // drain whatever is left so every queued entry is compared
      for (int n = 0; n < DEPTH + 1; n++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      end
      chk("drain count", {29'd0, count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
